// File: rtl/div_pkg.sv
// Shared types and defaults for the iterative divider slice.
package div_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring iteration: shift {rem, quo} left, subtract divisor, keep or restore.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] trial;
    logic             trial_neg;

    // One guard bit above the partial remainder makes the trial's sign bit the borrow.
    always_comb begin
        shifted   = {rem, quo[WIDTH-1]};
        trial     = shifted - {2'b00, divisor};
        trial_neg = trial[WIDTH+1];
        rem_next  = trial_neg ? shifted[WIDTH:0] : trial[WIDTH:0];
        quo_next  = {quo[WIDTH-2:0], ~trial_neg};
    end

endmodule

// File: rtl/iterative_divider.sv
// Multi-cycle restoring divider answering the ALU divide-start handshake; results feed HI/LO.
module iterative_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_begin,
    input  logic             div_sign,
    input  logic             div_dividend_sign,
    input  logic [WIDTH-1:0] div_dividend,
    input  logic [WIDTH-1:0] div_divisor,
    output logic [WIDTH-1:0] div_quotient,
    output logic [WIDTH-1:0] div_remainder,
    output logic             div_done,
    output logic             div_busy
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    div_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] divisor_q;
    logic             sign_q;
    logic             dividend_sign_q;
    logic [WIDTH:0]   rem_next;
    logic [WIDTH-1:0] quo_next;

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem     (rem_q),
        .quo     (quo_q),
        .divisor (divisor_q),
        .rem_next(rem_next),
        .quo_next(quo_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= '0;
            rem_q           <= '0;
            quo_q           <= '0;
            divisor_q       <= '0;
            sign_q          <= 1'b0;
            dividend_sign_q <= 1'b0;
            div_quotient    <= '0;
            div_remainder   <= '0;
            div_done        <= 1'b0;
            div_busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    div_done <= 1'b0;
                    if (div_begin) begin
                        quo_q           <= div_dividend;
                        divisor_q       <= div_divisor;
                        rem_q           <= '0;
                        sign_q          <= div_sign;
                        dividend_sign_q <= div_dividend_sign;
                        cnt             <= '0;
                        div_busy        <= 1'b1;
                        state           <= RUN;
                    end
                end
                RUN: begin
                    // Dropping div_begin is a flush: abandon silently, keep old results.
                    if (!div_begin) begin
                        div_busy <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        rem_q <= rem_next;
                        quo_q <= quo_next;
                        cnt   <= cnt + CNT_W'(1);
                        if (cnt == LAST_STEP) begin
                            div_quotient  <= sign_q ? -quo_next : quo_next;
                            div_remainder <= dividend_sign_q ? -rem_next[WIDTH-1:0]
                                                             : rem_next[WIDTH-1:0];
                            div_done      <= 1'b1;
                            state         <= DONE;
                        end
                    end
                end
                DONE: begin
                    div_done <= 1'b0;
                    div_busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    div_done <= 1'b0;
                    div_busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iterative_divider.sv
// Self-checking bench for iterative_divider against a plain-arithmetic divide model.
module tb_iterative_divider;

    logic        clk;
    logic        rst;
    logic        div_begin;
    logic        div_sign;
    logic        div_dividend_sign;
    logic [31:0] div_dividend;
    logic [31:0] div_divisor;
    logic [31:0] div_quotient;
    logic [31:0] div_remainder;
    logic        div_done;
    logic        div_busy;

    int checks;
    int passes;

    iterative_divider #(
        .WIDTH(32)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .div_begin        (div_begin),
        .div_sign         (div_sign),
        .div_dividend_sign(div_dividend_sign),
        .div_dividend     (div_dividend),
        .div_divisor      (div_divisor),
        .div_quotient     (div_quotient),
        .div_remainder    (div_remainder),
        .div_done         (div_done),
        .div_busy         (div_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Returns {remainder, quotient}; divide by zero gives all-ones / dividend.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            input logic s, input logic ds);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else begin
            q = a / b;
            r = a % b;
        end
        if (s)  q = 32'd0 - q;
        if (ds) r = 32'd0 - r;
        return {r, q};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycle 0 is the current cycle; reports the cycle of the first done and busy-low cycles seen.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic ds, input bit drop_after,
                         output int done_cyc, output int busy_low);
        div_dividend      = a;
        div_divisor       = b;
        div_sign          = s;
        div_dividend_sign = ds;
        div_begin         = 1'b1;
        done_cyc = -1;
        busy_low = 0;
        for (int c = 1; c <= 60 && done_cyc < 0; c++) begin
            tick();
            if (div_done === 1'b1) done_cyc = c;
            if (div_busy !== 1'b1) busy_low++;
        end
        if (drop_after) div_begin = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if ({div_quotient, div_remainder, div_done, div_busy} !== 66'd0)
            $display("FAIL reset_state: got q=%h r=%h done=%b busy=%b, want all 0",
                     div_quotient, div_remainder, div_done, div_busy);
        else passes++;
    endtask

    task automatic test_unsigned();
        int dc, bl;
        issue(32'd100, 32'd7, 1'b0, 1'b0, 1'b1, dc, bl);
        checks++;
        if (dc !== 33) $display("FAIL unsigned_latency: done in cycle %0d, want 33", dc);
        else passes++;
        checks++;
        if (bl !== 0) $display("FAIL unsigned_busy: busy low in %0d of cycles 1..33, want 0", bl);
        else passes++;
        checks++;
        if ({div_quotient, div_remainder} !== {32'd14, 32'd2})
            $display("FAIL unsigned_result: got q=%0d r=%0d, want q=14 r=2",
                     div_quotient, div_remainder);
        else passes++;
        tick();
        checks++;
        if ({div_done, div_busy} !== 2'b00)
            $display("FAIL done_pulse_width: cycle 34 done=%b busy=%b, want 0 0",
                     div_done, div_busy);
        else passes++;
        checks++;
        if ({div_quotient, div_remainder} !== {32'd14, 32'd2})
            $display("FAIL outputs_hold: got q=%0d r=%0d, want q=14 r=2",
                     div_quotient, div_remainder);
        else passes++;
    endtask

    task automatic test_signed();
        int dc, bl;
        issue(32'd7, 32'd2, 1'b1, 1'b1, 1'b1, dc, bl);
        tick();
        checks++;
        if ({div_quotient, div_remainder} !== {32'hFFFF_FFFD, 32'hFFFF_FFFF})
            $display("FAIL signed_result: got q=%h r=%h, want q=fffffffd r=ffffffff",
                     div_quotient, div_remainder);
        else passes++;
        issue(32'h8000_0000, 32'd1, 1'b1, 1'b0, 1'b1, dc, bl);
        tick();
        checks++;
        if ({div_quotient, div_remainder} !== {32'h8000_0000, 32'd0})
            $display("FAIL int_min_result: got q=%h r=%h, want q=80000000 r=0",
                     div_quotient, div_remainder);
        else passes++;
    endtask

    task automatic test_back_to_back();
        int dc, bl;
        issue(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b0, dc, bl);
        checks++;
        if ({div_quotient, div_remainder} !== {32'hFFFF_FFFF, 32'd0} || dc !== 33)
            $display("FAIL b2b_first: got q=%h r=%h cyc=%0d, want q=ffffffff r=0 cyc=33",
                     div_quotient, div_remainder, dc);
        else passes++;
        // begin stays high through DONE; the held request is taken in the next IDLE cycle.
        issue(32'd9, 32'd3, 1'b0, 1'b0, 1'b1, dc, bl);
        checks++;
        if (dc !== 34) $display("FAIL b2b_spacing: second done %0d cycles later, want 34", dc);
        else passes++;
        checks++;
        if ({div_quotient, div_remainder} !== {32'd3, 32'd0})
            $display("FAIL b2b_second: got q=%0d r=%0d, want q=3 r=0",
                     div_quotient, div_remainder);
        else passes++;
        tick();
    endtask

    task automatic test_div_zero();
        int dc, bl;
        issue(32'd5, 32'd0, 1'b0, 1'b0, 1'b1, dc, bl);
        tick();
        checks++;
        if ({div_quotient, div_remainder} !== {32'hFFFF_FFFF, 32'd5} || dc !== 33)
            $display("FAIL div_zero: got q=%h r=%h cyc=%0d, want q=ffffffff r=5 cyc=33",
                     div_quotient, div_remainder, dc);
        else passes++;
    endtask

    task automatic test_abort();
        int dones, dc, bl;
        logic [31:0] q0, r0;
        q0 = div_quotient;
        r0 = div_remainder;
        div_dividend = 32'd100;
        div_divisor  = 32'd7;
        div_sign     = 1'b0;
        div_dividend_sign = 1'b0;
        div_begin    = 1'b1;
        for (int c = 1; c <= 10; c++) tick();
        div_begin = 1'b0;
        tick();
        checks++;
        if (div_busy !== 1'b0) $display("FAIL abort_busy: cycle 11 busy=%b, want 0", div_busy);
        else passes++;
        dones = 0;
        for (int c = 0; c < 40; c++) begin
            if (div_done === 1'b1) dones++;
            tick();
        end
        checks++;
        if (dones !== 0) $display("FAIL abort_no_done: saw %0d done pulses, want 0", dones);
        else passes++;
        checks++;
        if ({div_quotient, div_remainder} !== {q0, r0})
            $display("FAIL abort_hold: got q=%h r=%h, want q=%h r=%h",
                     div_quotient, div_remainder, q0, r0);
        else passes++;
        issue(32'd9, 32'd3, 1'b0, 1'b0, 1'b1, dc, bl);
        tick();
        checks++;
        if ({div_quotient, div_remainder} !== {32'd3, 32'd0} || dc !== 33)
            $display("FAIL abort_recover: got q=%0d r=%0d cyc=%0d, want q=3 r=0 cyc=33",
                     div_quotient, div_remainder, dc);
        else passes++;
    endtask

    task automatic test_reset_mid_op();
        int dones, dc, bl;
        div_dividend = 32'hDEAD_BEEF;
        div_divisor  = 32'd13;
        div_sign     = 1'b1;
        div_dividend_sign = 1'b1;
        div_begin    = 1'b1;
        for (int c = 1; c <= 15; c++) tick();
        rst = 1'b1;
        #1;
        checks++;
        if ({div_quotient, div_remainder, div_done, div_busy} !== 66'd0)
            $display("FAIL reset_mid_op: got q=%h r=%h done=%b busy=%b, want all 0",
                     div_quotient, div_remainder, div_done, div_busy);
        else passes++;
        div_begin = 1'b0;
        tick();
        rst = 1'b0;
        dones = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (div_done === 1'b1) dones++;
        end
        checks++;
        if (dones !== 0) $display("FAIL reset_no_done: saw %0d done pulses, want 0", dones);
        else passes++;
        issue(32'd20, 32'd6, 1'b0, 1'b0, 1'b1, dc, bl);
        tick();
        checks++;
        if ({div_quotient, div_remainder} !== {32'd3, 32'd2} || dc !== 33)
            $display("FAIL reset_recover: got q=%0d r=%0d cyc=%0d, want q=3 r=2 cyc=33",
                     div_quotient, div_remainder, dc);
        else passes++;
    endtask

    task automatic test_random();
        int dc, bl;
        logic [31:0] a, b;
        logic s, ds;
        logic [63:0] exp;
        for (int n = 0; n < 24; n++) begin
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : 32'($urandom);
            if (n % 5 == 1) b = a >> $urandom_range(0, 8);
            s  = 1'($urandom_range(0, 1));
            ds = 1'($urandom_range(0, 1));
            exp = ref_div(a, b, s, ds);
            issue(a, b, s, ds, 1'b1, dc, bl);
            tick();
            checks++;
            if ({div_remainder, div_quotient} !== exp || dc !== 33)
                $display("FAIL random_%0d: %h/%h s=%b ds=%b got q=%h r=%h cyc=%0d, want q=%h r=%h cyc=33",
                         n, a, b, s, ds, div_quotient, div_remainder, dc, exp[31:0], exp[63:32]);
            else passes++;
        end
    endtask

    initial begin
        checks = 0;
        passes = 0;
        rst = 1'b1;
        div_begin = 1'b0;
        div_sign = 1'b0;
        div_dividend_sign = 1'b0;
        div_dividend = '0;
        div_divisor = '0;
        tick();
        tick();
        test_reset();
        rst = 1'b0;
        tick();
        test_unsigned();
        test_signed();
        test_back_to_back();
        test_div_zero();
        test_abort();
        test_reset_mid_op();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
